// File: rtl/cpu_pkg.sv
// cpu_pkg: pipeline-control types and constants shared by the CPU control blocks.
package cpu_pkg;
    typedef enum logic [1:0] {RUN, MD_WAIT, MD_ISSUE} state_t;
    localparam int REG_W = 5;
    localparam int PERF_W = 16;
    localparam logic [31:0] NOP = 32'b0;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             inc,
    output logic [WIDTH-1:0] o_count
);
    always_ff @(posedge CLK or negedge RST_n)
        if (!RST_n)
            o_count <= '0;
        else if (inc && !(&o_count))
            o_count <= o_count + 1'b1;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: advance/stall/flush sequencing of PC, IF/ID and ID/EX with perf counters.
// Define MULDIV_STALL_EN to enable the multi-cycle mult/div stall.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int MULDIV_CYCLES = 32
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic [REG_W-1:0]  ID_rs,
    input  logic [REG_W-1:0]  ID_rt,
    input  logic              ID_uses_rs,
    input  logic              ID_uses_rt,
    input  logic              ID_muldiv,
    input  logic              EX_memread,
    input  logic [REG_W-1:0]  EX_rd,
    input  logic              EX_branch_taken,
    output logic              PC_write,
    output logic              IFID_write,
    output logic              IFID_flush,
    output logic              IDEX_bubble,
    output logic              busy,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);
    state_t w_state;
    logic   w_lu, w_md, w_pc, w_ifid, w_iflush, w_bub, w_flush_inc, w_unused;
    assign w_lu = EX_memread && (EX_rd != '0) &&
                  ((ID_uses_rs && ID_rs == EX_rd) || (ID_uses_rt && ID_rt == EX_rd));
`ifdef MULDIV_STALL_EN
    localparam int MD_W = $clog2(MULDIV_CYCLES + 1);
    state_t          r_state, w_next;
    logic [MD_W-1:0] r_md_cnt, w_md_next;
    assign w_state  = r_state;
    assign w_md     = ID_muldiv;
    assign w_unused = |NOP;
    always_ff @(posedge CLK or negedge RST_n)
        if (!RST_n) begin
            r_state  <= RUN;
            r_md_cnt <= '0;
        end else begin
            r_state  <= w_next;
            r_md_cnt <= w_md_next;
        end
    always_comb begin
        w_next    = r_state;
        w_md_next = r_md_cnt;
        case (r_state)
            RUN:
                if (!EX_branch_taken && !w_lu && ID_muldiv) begin
                    w_next    = MD_WAIT;
                    w_md_next = MD_W'(MULDIV_CYCLES - 1);
                end
            MD_WAIT: begin
                w_md_next = r_md_cnt - 1'b1;
                w_next    = (r_md_cnt == MD_W'(1)) ? MD_ISSUE : MD_WAIT;
            end
            default: w_next = RUN;
        endcase
    end
`else
    assign w_state  = RUN;
    assign w_md     = 1'b0;
    assign w_unused = |{NOP, ID_muldiv, MULDIV_CYCLES == 0};
`endif
    // Branch wins over load-use and mult/div: the ID instruction is squashed anyway.
    always_comb begin
        w_pc        = 1'b1;
        w_ifid      = 1'b1;
        w_iflush    = 1'b0;
        w_bub       = 1'b0;
        w_flush_inc = 1'b0;
        if (w_state == RUN && EX_branch_taken) begin
            w_iflush    = 1'b1;
            w_bub       = 1'b1;
            w_flush_inc = 1'b1;
        end else if (w_state == MD_WAIT || (w_state == RUN && (w_lu || w_md))) begin
            w_pc   = 1'b0;
            w_ifid = 1'b0;
            w_bub  = 1'b1;
        end
    end
    assign PC_write    = RST_n & w_pc;
    assign IFID_write  = RST_n & w_ifid;
    assign IFID_flush  = !RST_n | w_iflush;
    assign IDEX_bubble = !RST_n | w_bub;
    assign busy        = (w_state != RUN);
    sat_counter #(.WIDTH(PERF_W)) u_stall_cnt (
        .CLK(CLK), .RST_n(RST_n), .inc(!w_pc), .o_count(stall_cnt)
    );
    sat_counter #(.WIDTH(PERF_W)) u_flush_cnt (
        .CLK(CLK), .RST_n(RST_n), .inc(w_flush_inc), .o_count(flush_cnt)
    );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized and directed checks of hazard_ctrl against a cycle model.
module tb_hazard_ctrl;
    localparam int MC = 4;
`ifdef MULDIV_STALL_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif
    logic CLK = 1'b0, rst_n = 1'b0;
    logic [4:0] ID_rs = '0, ID_rt = '0, EX_rd = '0;
    logic ID_uses_rs = 0, ID_uses_rt = 0, ID_muldiv = 0, EX_memread = 0, EX_branch_taken = 0;
    logic PC_write, IFID_write, IFID_flush, IDEX_bubble, busy;
    logic [15:0] stall_cnt, flush_cnt;
    int n = 0, bad = 0;
    int md_left = 0, e_stall = 0, e_flush = 0;
    bit md_iss = 0;
    logic [4:0] exp_o;
    hazard_ctrl #(.MULDIV_CYCLES(MC)) dut (
        .CLK(CLK), .RST_n(rst_n), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rs(ID_uses_rs),
        .ID_uses_rt(ID_uses_rt), .ID_muldiv(ID_muldiv), .EX_memread(EX_memread), .EX_rd(EX_rd),
        .EX_branch_taken(EX_branch_taken), .PC_write(PC_write), .IFID_write(IFID_write),
        .IFID_flush(IFID_flush), .IDEX_bubble(IDEX_bubble), .busy(busy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );
    always #5 CLK = ~CLK;
    function automatic bit lu();
        return EX_memread && EX_rd != 0 &&
               ((ID_uses_rs && ID_rs == EX_rd) || (ID_uses_rt && ID_rt == EX_rd));
    endfunction
    // exp_o = {PC_write, IFID_write, IFID_flush, IDEX_bubble, busy}
    task automatic model_eval();
        if (!rst_n) exp_o = 5'b00110;
        else if (md_left > 0) exp_o = 5'b00011;
        else if (md_iss) exp_o = 5'b11001;
        else if (EX_branch_taken) exp_o = 5'b11110;
        else if (lu() || (MD_EN && ID_muldiv)) exp_o = 5'b00010;
        else exp_o = 5'b11000;
    endtask
    task automatic model_adv();
        model_eval();
        if (!rst_n) begin
            md_left = 0; md_iss = 0; e_stall = 0; e_flush = 0;
            return;
        end
        if (!exp_o[4] && e_stall < 65535) e_stall++;
        if (md_left > 0) begin
            md_left--;
            if (md_left == 0) md_iss = 1;
        end else if (md_iss) md_iss = 0;
        else if (EX_branch_taken) begin
            if (e_flush < 65535) e_flush++;
        end else if (!lu() && MD_EN && ID_muldiv) md_left = MC - 1;
    endtask
    task automatic clr_in();
        {ID_rs, ID_rt, EX_rd} = '0;
        {ID_uses_rs, ID_uses_rt, ID_muldiv, EX_memread, EX_branch_taken} = '0;
    endtask
    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK); model_eval();
            n++; if ({PC_write, IFID_write, IFID_flush, IDEX_bubble, busy} !== exp_o) begin
                bad++; $display("FAIL reset_outs got=%b want=%b", {PC_write, IFID_write, IFID_flush, IDEX_bubble, busy}, exp_o); end
            n++; if ({stall_cnt, flush_cnt} !== 32'h0) begin
                bad++; $display("FAIL reset_cnts got=%h/%h want=0/0", stall_cnt, flush_cnt); end
            model_adv();
        end
        @(posedge CLK); #1; rst_n = 1;
    endtask
    task automatic test_load_use();
        for (int i = 0; i < 3; i++) begin
            clr_in();
            if (i == 0) begin EX_memread = 1; EX_rd = 5; ID_rs = 5; ID_uses_rs = 1; end
            @(negedge CLK); model_eval();
            n++; if ({PC_write, IFID_write, IFID_flush, IDEX_bubble, busy} !== exp_o) begin
                bad++; $display("FAIL load_use_outs cyc=%0d got=%b want=%b", i, {PC_write, IFID_write, IFID_flush, IDEX_bubble, busy}, exp_o); end
            n++; if (stall_cnt !== 16'(e_stall)) begin
                bad++; $display("FAIL load_use_stall_cnt got=%0d want=%0d", stall_cnt, e_stall); end
            model_adv(); @(posedge CLK); #1;
        end
    endtask
    task automatic test_reg_zero();
        for (int i = 0; i < 2; i++) begin
            clr_in(); EX_memread = 1; ID_uses_rs = 1; ID_uses_rt = i[0];
            @(negedge CLK); model_eval();
            n++; if ({PC_write, IFID_write, IFID_flush, IDEX_bubble, busy} !== exp_o) begin
                bad++; $display("FAIL reg_zero_outs got=%b want=%b", {PC_write, IFID_write, IFID_flush, IDEX_bubble, busy}, exp_o); end
            model_adv(); @(posedge CLK); #1;
        end
    endtask
    task automatic test_branch_priority();
        for (int i = 0; i < 3; i++) begin
            clr_in(); EX_branch_taken = (i < 2); EX_memread = 1; EX_rd = 7; ID_rt = 7;
            ID_uses_rt = 1; ID_muldiv = (i == 1);
            @(negedge CLK); model_eval();
            n++; if ({PC_write, IFID_write, IFID_flush, IDEX_bubble, busy} !== exp_o) begin
                bad++; $display("FAIL branch_outs cyc=%0d got=%b want=%b", i, {PC_write, IFID_write, IFID_flush, IDEX_bubble, busy}, exp_o); end
            n++; if ({stall_cnt, flush_cnt} !== {16'(e_stall), 16'(e_flush)}) begin
                bad++; $display("FAIL branch_cnts got=%0d/%0d want=%0d/%0d", stall_cnt, flush_cnt, e_stall, e_flush); end
            model_adv(); @(posedge CLK); #1;
        end
    endtask
    task automatic test_muldiv();
        logic [15:0] s0 = stall_cnt;
        for (int i = 0; i < 7; i++) begin
            clr_in(); ID_muldiv = (i < 5);
            @(negedge CLK); model_eval();
            n++; if ({PC_write, IFID_write, IFID_flush, IDEX_bubble, busy} !== exp_o) begin
                bad++; $display("FAIL muldiv_outs cyc=%0d got=%b want=%b", i, {PC_write, IFID_write, IFID_flush, IDEX_bubble, busy}, exp_o); end
            model_adv(); @(posedge CLK); #1;
        end
        n++; if (16'(stall_cnt - s0) !== (MD_EN ? 16'd4 : 16'd0)) begin
            bad++; $display("FAIL muldiv_stall_delta got=%0d want=%0d", 16'(stall_cnt - s0), MD_EN ? 4 : 0); end
    endtask
    task automatic test_reset_mid_wait();
        clr_in(); ID_muldiv = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK); model_adv(); @(posedge CLK); #1;
        end
        rst_n = 0; #1;
        model_adv(); model_eval();
        n++; if ({PC_write, IFID_write, IFID_flush, IDEX_bubble, busy} !== exp_o) begin
            bad++; $display("FAIL midwait_reset_outs got=%b want=%b", {PC_write, IFID_write, IFID_flush, IDEX_bubble, busy}, exp_o); end
        n++; if ({stall_cnt, flush_cnt} !== 32'h0) begin
            bad++; $display("FAIL midwait_reset_cnts got=%h/%h want=0/0", stall_cnt, flush_cnt); end
        @(posedge CLK); #1; rst_n = 1; ID_muldiv = 0;
        @(negedge CLK); model_eval();
        n++; if ({PC_write, IFID_write, IFID_flush, IDEX_bubble, busy} !== 5'b11000) begin
            bad++; $display("FAIL midwait_release got=%b want=11000", {PC_write, IFID_write, IFID_flush, IDEX_bubble, busy}); end
        model_adv(); @(posedge CLK); #1;
    endtask
    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            ID_rs = 5'($urandom_range(0, 3)); ID_rt = 5'($urandom_range(0, 3));
            EX_rd = 5'($urandom_range(0, 3)); ID_uses_rs = 1'($urandom);
            ID_uses_rt = 1'($urandom); EX_memread = 1'($urandom);
            EX_branch_taken = ($urandom_range(0, 5) == 0); ID_muldiv = ($urandom_range(0, 7) == 0);
            @(negedge CLK); model_eval();
            n++; if ({PC_write, IFID_write, IFID_flush, IDEX_bubble, busy} !== exp_o) begin
                bad++; $display("FAIL random_outs cyc=%0d got=%b want=%b", i, {PC_write, IFID_write, IFID_flush, IDEX_bubble, busy}, exp_o); end
            n++; if ({stall_cnt, flush_cnt} !== {16'(e_stall), 16'(e_flush)}) begin
                bad++; $display("FAIL random_cnts cyc=%0d got=%0d/%0d want=%0d/%0d", i, stall_cnt, flush_cnt, e_stall, e_flush); end
            model_adv(); @(posedge CLK); #1;
        end
    endtask
    task automatic test_saturation();
        clr_in(); EX_memread = 1; EX_rd = 9; ID_rs = 9; ID_uses_rs = 1;
        for (int i = 0; i < 65600; i++) begin
            @(negedge CLK); model_adv(); @(posedge CLK); #1;
        end
        n++; if (stall_cnt !== 16'hFFFF || e_stall != 65535) begin
            bad++; $display("FAIL saturation got=%h want=ffff", stall_cnt); end
        clr_in();
        @(negedge CLK);
        n++; if ({PC_write, stall_cnt} !== {1'b1, 16'hFFFF}) begin
            bad++; $display("FAIL saturation_hold got=%b/%h want=1/ffff", PC_write, stall_cnt); end
    endtask
    initial begin
        test_reset();
        test_load_use();
        test_reg_zero();
        test_branch_priority();
        test_muldiv();
        test_reset_mid_wait();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", n, bad);
        $finish;
    end
endmodule
